// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of retired stores that drains into a single-port data memory when no load needs the port.
// Build macro STORE_FWD_EN: loads take data from the youngest matching buffered store instead of stalling until it drains.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              enq;
  logic              drain;
  logic              ld_hit;
  logic              ld_serviced;
  logic [PTR_W-1:0]  idx;
`ifdef STORE_FWD_EN
  logic [DATA_W-1:0] fwd_data;
`endif

  assign full     = (count_q == FULL_CNT);
  assign st_ready = !full;
  assign empty    = (count_q == '0);
  assign enq      = st_valid && st_ready;

  // Walk valid entries oldest to youngest so the last hit is the youngest match.
  always_comb begin
    ld_hit = 1'b0;
    idx    = head_q;
`ifdef STORE_FWD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (addr_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hit = 1'b1;
`ifdef STORE_FWD_EN
        fwd_data = data_q[idx];
`endif
      end
    end
  end

  // Port arbitration: a full buffer always drains so stores cannot be starved by loads.
  always_comb begin
`ifdef STORE_FWD_EN
    ld_stall = ld_valid && full;
`else
    ld_stall = ld_valid && (full || ld_hit);
`endif
    ld_serviced    = ld_valid && !ld_stall;
    drain          = !ld_serviced && !empty;
    mem_write      = drain;
    mem_address    = '0;
    mem_write_data = '0;
    ld_data        = '0;
    if (drain) begin
      mem_address    = addr_q[head_q];
      mem_write_data = data_q[head_q];
    end else if (ld_serviced) begin
      mem_address = ld_addr;
    end
    if (ld_serviced) begin
`ifdef STORE_FWD_EN
      ld_data = ld_hit ? fwd_data : mem_read_data;
`else
      ld_data = mem_read_data;
`endif
    end
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = drain ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (enq) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
